// File: rtl/instr_fetch_decode.sv
// -----------------------------------------------------------------------------
// instr_fetch_decode
//   Fetch/decode front end of the 16-bit core. Walks the PC, reads words from
//   a 1-cycle-latency instruction ROM, and splits each word into fields that
//   are handed to the sign-extend stage and register file via valid/ready.
//   Branch redirects reload the PC and flush any in-flight fetch.
//
// Ports
//   clk          in   1     rising-edge clock
//   rst_n        in   1     asynchronous active-low reset
//   imem_en      out  1     ROM read strobe (data returns one cycle later)
//   imem_addr    out  PC_W  ROM word address (= pc)
//   imem_rdata   in   16    ROM read data
//   redirect     in   1     branch taken: load redirect_pc and flush
//   redirect_pc  in   PC_W  branch target
//   out_valid    out  1     decoded instruction presented
//   out_ready    in   1     consumer accepts when out_valid & out_ready
//   out_pc       out  PC_W  address of the presented instruction
//   opcode       out  4     instr[15:12]
//   rd           out  4     instr[11:8]
//   rs1          out  4     instr[7:4]
//   rs2          out  4     instr[3:0]
//   imm8         out  8     instr[7:0]
//   imm_src      out  1     IMM_OP_MASK[opcode]
//   halted       out  1     halt instruction accepted; fetching stopped
// -----------------------------------------------------------------------------
module instr_fetch_decode #(
  parameter int          PC_W        = 8,
  parameter logic [15:0] IMM_OP_MASK = 16'h01F0,
  parameter logic [3:0]  HALT_OP     = 4'hF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]      opcode,
  output logic [3:0]      rd,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic [7:0]      imm8,
  output logic            imm_src,
  output logic            halted
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [2:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_instr;
  logic [PC_W-1:0] r_out_pc;

  logic [2:0]      w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic            w_capture;
  logic            w_xfer;

  assign w_xfer = (r_state == S_HOLD) && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (redirect) w_pc_nxt = redirect_pc;
      end
      S_REQ: begin
        // A redirect here abandons the read just issued; its data is never captured.
        if (redirect) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = S_REQ;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        // An accepted halt wins over a simultaneous redirect: the core stops.
        if (w_xfer && (r_instr[15:12] == HALT_OP)) begin
          w_state_nxt = S_HALT;
        end else if (redirect) begin
          // Covers both the dropped-instruction case and a transfer in the same
          // cycle; either way the next fetch comes from the branch target.
          w_pc_nxt    = redirect_pc;
          w_state_nxt = S_REQ;
        end else if (w_xfer) begin
          w_pc_nxt    = r_pc + PC_ONE;
          w_state_nxt = S_REQ;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_instr  <= 16'h0000;
      r_out_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_capture) begin
        r_instr  <= imem_rdata;
        r_out_pc <= r_pc;
      end
    end
  end

  assign imem_en   = (r_state == S_REQ);
  assign imem_addr = r_pc;
  assign out_valid = (r_state == S_HOLD);
  assign halted    = (r_state == S_HALT);
  assign out_pc    = r_out_pc;

  // Fields decode straight off the instruction register, so they hold their
  // last values whenever out_valid is low.
  assign opcode  = r_instr[15:12];
  assign rd      = r_instr[11:8];
  assign rs1     = r_instr[7:4];
  assign rs2     = r_instr[3:0];
  assign imm8    = r_instr[7:0];
  assign imm_src = IMM_OP_MASK[r_instr[15:12]];

endmodule
